univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
- Parametrised successor to the plain parallel-in/parallel-out register.
- Adds free-running shift/rotate modes, serial in/out at both ends, and a counted burst-shift engine with a busy/done handshake.
- Used as the general-purpose data-holding and serialising stage ahead of serial links and bit-manipulation datapaths.

Parameters:
- N, 8, register width in bits (N >= 2).
- CNT_W, $clog2(N)+1, width of the burst shift count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- load  input  1  parallel load strobe; highest priority.
- p_data  input  N  parallel load data.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 rotate right.
- sin_msb  input  1  serial bit entering at bit N-1 on a right shift.
- sin_lsb  input  1  serial bit entering at bit 0 on a left shift.
- start  input  1  burst request; sampled only in IDLE.
- shift_cnt  input  CNT_W  number of burst shifts, latched with start.
- q  output  N  register contents.
- sout_lsb  output  1  equals q[0], combinational.
- sout_msb  output  1  equals q[N-1], combinational.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse, high while in DONE.

Behaviour:
- Asynchronous reset, active-high.
  - Outputs: q=0, busy=0, done=0.
  - Internal: state=IDLE, remaining count=0, latched mode=00.
  - Reset mid-burst aborts the burst; no done pulse.
- Shift operations:
  - Right: q <= {sin_msb, q[N-1:1]}.
  - Left: q <= {q[N-2:0], sin_lsb}.
  - Rotate right: q <= {q[0], q[N-1:1]}.
  - Hold: q unchanged.
- Priority at each edge: load > burst activity > live mode.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - load=1: q <= p_data; start is ignored in that cycle.
  - start=1 with shift_cnt>0: latch mode and shift_cnt, go to SHIFT; q unchanged at this edge.
  - start=1 with shift_cnt=0, or with mode=00: go to DONE; q unchanged.
  - Otherwise: apply live mode.
- SHIFT:
  - Each edge applies the latched mode once and decrements remaining.
  - The edge that performs the final shift (remaining==1) moves to DONE.
  - busy is high for exactly shift_cnt cycles.
  - Live mode and start are ignored. sin_msb and sin_lsb are sampled live each shift.
  - load=1 during SHIFT: q <= p_data, burst aborted, go to IDLE, no done pulse.
- DONE:
  - done=1 for exactly one cycle, q holds, then IDLE.
  - load in DONE still loads q; the state still goes to IDLE.
  - start in DONE is ignored.
- shift_cnt > N is legal.
  - Shifts continue with serial fill; a rotate wraps modulo N.
- Latency:
  - Load: 1 cycle.
  - Burst of k: q final k edges after the start edge; done high in the following cycle.

Optional Feature:
- Macro: USR_PARITY_EN.
- Defined: adds output port parity (1 bit) = ^q, combinational; reads 0 after reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package usr_pkg holds:
  - mode_t enum: MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_ROR=2'b11.
  - state_t enum: IDLE, SHIFT, DONE.
- One sub-module, usr_shift_core.
  - Combinational next-value: inputs q, mode, sin_msb, sin_lsb; output next q.
  - Shared by the live-mode path and the burst path.
- The FSM and counter stay in the top module.

Test Plan:
- Reset: assert rst mid-burst (cnt=5, after 2 shifts) -> q=0, busy=0 immediately; no done pulse after release.
- Load/hold: load p_data=8'hAA, then mode=00 for 4 cycles -> q=8'hAA throughout; sout_msb=1, sout_lsb=0.
- Right burst: q=8'hAA, mode=01, sin_msb=0, start with shift_cnt=3 -> busy high 3 cycles, q=8'h55, 8'h2A, 8'h15; done pulses one cycle.
- Left burst then rotate:
  - q=8'hAA, mode=10, sin_lsb=1, cnt=3 -> q=8'h57.
  - Then load 8'h81, live mode=11 for 1 cycle -> q=8'hC0.
- Edge cases:
  - shift_cnt=0 -> no q change, done pulses on the next cycle.
  - start while busy -> ignored.
  - load=1 during the 2nd burst cycle with p_data=8'h3C -> q=8'h3C, busy=0, no done.
- With USR_PARITY_EN defined: q=8'h57 -> parity=1; q=8'hC0 -> parity=0.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: shift modes and burst FSM states.
package usr_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_ROR  = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/usr_shift_core.sv
// Combinational next-value datapath for one shift step; shared by the live-mode and burst paths.
module usr_shift_core
   import usr_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] q_i,
   input  mode_t        mode_i,
   input  logic         sin_msb_i,
   input  logic         sin_lsb_i,
   output logic [N-1:0] q_next_o
);

   always_comb begin
      q_next_o = q_i;
      case (mode_i)
         MODE_HOLD: q_next_o = q_i;
         MODE_SHR:  q_next_o = {sin_msb_i, q_i[N-1:1]};
         MODE_SHL:  q_next_o = {q_i[N-2:0], sin_lsb_i};
         MODE_ROR:  q_next_o = {q_i[0], q_i[N-1:1]};
         default:   q_next_o = q_i;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with parallel load, live shift/rotate modes and a counted burst engine.
// Optional parity output is built when USR_PARITY_EN is defined.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int N     = 8,
   parameter int CNT_W = $clog2(N) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [N-1:0]     p_data,
   input  logic [1:0]       mode,
   input  logic             sin_msb,
   input  logic             sin_lsb,
   input  logic             start,
   input  logic [CNT_W-1:0] shift_cnt,
   output logic [N-1:0]     q,
   output logic             sout_lsb,
   output logic             sout_msb,
   output logic             busy,
`ifdef USR_PARITY_EN
   output logic             done,
   output logic             parity
`else
   output logic             done
`endif
);

   state_t           state_q, state_d;
   mode_t            mode_q, mode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     q_q, q_d;
   logic [N-1:0]     q_next;
   mode_t            core_mode;

   // The burst replays the mode captured at start; otherwise the live mode drives the core.
   assign core_mode = (state_q == SHIFT) ? mode_q : mode_t'(mode);

   usr_shift_core #(.N(N)) u_core (
      .q_i       (q_q),
      .mode_i    (core_mode),
      .sin_msb_i (sin_msb),
      .sin_lsb_i (sin_lsb),
      .q_next_o  (q_next)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               q_d = p_data;
            end else if (start) begin
               if ((shift_cnt == '0) || (mode_t'(mode) == MODE_HOLD)) begin
                  state_d = DONE;
               end else begin
                  state_d = SHIFT;
                  mode_d  = mode_t'(mode);
                  cnt_d   = shift_cnt;
               end
            end else begin
               q_d = q_next;
            end
         end
         SHIFT: begin
            if (load) begin
               q_d     = p_data;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               q_d   = q_next;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
         end
         DONE: begin
            if (load) q_d = p_data;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= MODE_HOLD;
         cnt_q   <= '0;
         q_q     <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
      end
   end

   assign q        = q_q;
   assign sout_lsb = q_q[0];
   assign sout_msb = q_q[N-1];
   assign busy     = (state_q == SHIFT);
   assign done     = (state_q == DONE);
`ifdef USR_PARITY_EN
   assign parity   = ^q_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (N=8); parity checks run when USR_PARITY_EN is defined.
module tb_univ_shift_reg;

   localparam int N     = 8;
   localparam int CNT_W = $clog2(N) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             load;
   logic [N-1:0]     p_data;
   logic [1:0]       mode;
   logic             sin_msb;
   logic             sin_lsb;
   logic             start;
   logic [CNT_W-1:0] shift_cnt;
   logic [N-1:0]     q;
   logic             sout_lsb;
   logic             sout_msb;
   logic             busy;
   logic             done;
`ifdef USR_PARITY_EN
   logic             parity;
`endif

   int tests  = 0;
   int failed = 0;
   logic [N-1:0] exp_q[$];

   univ_shift_reg #(.N(N), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .p_data    (p_data),
      .mode      (mode),
      .sin_msb   (sin_msb),
      .sin_lsb   (sin_lsb),
      .start     (start),
      .shift_cnt (shift_cnt),
      .q         (q),
      .sout_lsb  (sout_lsb),
      .sout_msb  (sout_msb),
      .busy      (busy),
`ifdef USR_PARITY_EN
      .done      (done),
      .parity    (parity)
`else
      .done      (done)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   // checking
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // drivers: inputs change and outputs are sampled 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [N-1:0] val);
      load   = 1'b1;
      p_data = val;
      step();
      load   = 1'b0;
   endtask

   task automatic start_burst(input logic [1:0] m, input logic [CNT_W-1:0] cnt);
      mode      = m;
      shift_cnt = cnt;
      start     = 1'b1;
      step();
      start     = 1'b0;
      mode      = 2'b00;
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; p_data = '0; mode = 2'b00;
      sin_msb = 1'b0; sin_lsb = 1'b0; start = 1'b0; shift_cnt = '0;
      step(); step();
      check("reset_q", q, 8'h00);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
`ifdef USR_PARITY_EN
      check("reset_parity", parity, 1'b0);
`endif
      rst = 1'b0;
      step();

      // load and hold
      do_load(8'hAA);
      for (int i = 0; i < 4; i++) begin
         step();
         check("hold_q", q, 8'hAA);
      end
      check("hold_sout_msb", sout_msb, 1'b1);
      check("hold_sout_lsb", sout_lsb, 1'b0);

      // right burst of 3; live mode changes during the burst are ignored
      sin_msb = 1'b0;
      exp_q.push_back(8'h55); exp_q.push_back(8'h2A); exp_q.push_back(8'h15);
      start_burst(2'b01, 3);
      check("shr_start_q", q, 8'hAA);
      check("shr_start_busy", busy, 1'b1);
      mode = 2'b10;
      for (int i = 0; i < 3; i++) begin
         step();
         check("shr_q", q, exp_q.pop_front());
         check("shr_busy", busy, (i < 2) ? 1'b1 : 1'b0);
      end
      mode = 2'b00;
      check("shr_done", done, 1'b1);
      step();
      check("shr_done_clear", done, 1'b0);
      check("shr_hold_after", q, 8'h15);

      // left burst of 3, then a single live rotate
      do_load(8'hAA);
      sin_lsb = 1'b1;
      start_burst(2'b10, 3);
      step(); step(); step();
      check("shl_q", q, 8'h57);
      check("shl_done", done, 1'b1);
`ifdef USR_PARITY_EN
      check("parity_57", parity, 1'b1);
`endif
      step();
      sin_lsb = 1'b0;
      do_load(8'h81);
      mode = 2'b11;
      step();
      mode = 2'b00;
      check("ror_live_q", q, 8'hC0);
`ifdef USR_PARITY_EN
      check("parity_c0", parity, 1'b0);
`endif

      // zero-count start: straight to DONE, q unchanged
      do_load(8'h5A);
      start_burst(2'b01, 0);
      check("cnt0_q", q, 8'h5A);
      check("cnt0_done", done, 1'b1);
      check("cnt0_busy", busy, 1'b0);
      step();
      check("cnt0_done_clear", done, 1'b0);

      // start with hold mode is also an immediate DONE
      start_burst(2'b00, 3);
      check("hold_start_done", done, 1'b1);
      check("hold_start_busy", busy, 1'b0);
      step();

      // start while busy is ignored: busy lasts only the original 2 cycles
      do_load(8'hF0);
      sin_msb = 1'b1;
      start_burst(2'b01, 2);
      start = 1'b1; shift_cnt = 5; mode = 2'b10;
      step();
      check("restart_q1", q, 8'hF8);
      check("restart_busy1", busy, 1'b1);
      step();
      start = 1'b0; mode = 2'b00;
      check("restart_q2", q, 8'hFC);
      check("restart_busy2", busy, 1'b0);
      check("restart_done", done, 1'b1);
      step();
      sin_msb = 1'b0;

      // load during the 2nd burst cycle aborts the burst
      do_load(8'hFF);
      start_burst(2'b01, 4);
      step();
      check("abort_pre_q", q, 8'h7F);
      load = 1'b1; p_data = 8'h3C;
      step();
      load = 1'b0;
      check("abort_q", q, 8'h3C);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      step();
      check("abort_done_later", done, 1'b0);
      check("abort_q_later", q, 8'h3C);

      // count larger than N: rotate by 9 wraps to rotate by 1
      do_load(8'h81);
      start_burst(2'b11, 9);
      for (int i = 0; i < 9; i++) step();
      check("ror9_q", q, 8'hC0);
      check("ror9_done", done, 1'b1);

      // load while in DONE still loads and returns to IDLE
      load = 1'b1; p_data = 8'h69;
      step();
      load = 1'b0;
      check("done_load_q", q, 8'h69);
      check("done_load_done", done, 1'b0);
      check("done_load_busy", busy, 1'b0);

      // async reset mid-burst: cnt 5, asserted after 2 shifts
      do_load(8'hFF);
      start_burst(2'b01, 5);
      step(); step();
      check("rst_pre_q", q, 8'h3F);
      #2 rst = 1'b1;
      #1;
      check("rst_async_q", q, 8'h00);
      check("rst_async_busy", busy, 1'b0);
      step();
      rst = 1'b0;
      begin
         int done_seen;
         done_seen = 0;
         for (int i = 0; i < 8; i++) begin
            step();
            if (done === 1'b1) done_seen++;
         end
         check("rst_no_done", done_seen, 0);
      end
      check("rst_q_stays", q, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
